// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 4;
    localparam int unsigned CNT_W = 16;

    localparam logic [REG_W-1:0] PC_IDX  = 4'hF;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // In-flight instruction summary for the EXE and MEM stages
    typedef struct packed {
        logic             valid;
        logic             wb_en;
        logic             mem_r_en;
        logic [REG_W-1:0] dest;
    } slot_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2,
        WAIT  = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Combinational RAW compare of the ID sources against the EXE/MEM writers.
// FORWARDING_EN: only a load in EXE can cause a stall (load-use).
module hazard_match
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             use_src1,
    input  logic             two_src,
    input  logic             id_valid,
    input  slot_t            exe_s,
    input  slot_t            mem_s,
    output logic             raw_c
);

`ifdef FORWARDING_EN
    // ALU results are forwarded; only a load in EXE is still unresolved
    function automatic logic match(input logic [REG_W-1:0] s, input slot_t x);
        return x.valid & x.wb_en & x.mem_r_en & (x.dest == s) & (s != PC_IDX);
    endfunction

    logic unused_mem_slot;
    assign unused_mem_slot = ^mem_s;

    assign raw_c = id_valid & ((use_src1 & match(src1, exe_s)) |
                               (two_src  & match(src2, exe_s)));
`else
    function automatic logic match(input logic [REG_W-1:0] s, input slot_t x);
        return x.valid & x.wb_en & (x.dest == s) & (s != PC_IDX);
    endfunction

    logic unused_load_bits;
    assign unused_load_bits = exe_s.mem_r_en ^ mem_s.mem_r_en;

    assign raw_c = id_valid &
                   ((use_src1 & (match(src1, exe_s) | match(src1, mem_s))) |
                    (two_src  & (match(src2, exe_s) | match(src2, mem_s))));
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall on RAW, flush on taken branch, freeze on busy memory.
// Build option: FORWARDING_EN restricts stalls to load-use in EXE.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             Two_src,
    input  logic             use_src1,
    input  logic             id_valid,
    input  logic             WB_EN_ID,
    input  logic             MEM_R_EN_ID,
    input  logic [REG_W-1:0] Dest_ID,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             hazard,
    output logic             flush,
    output logic             freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    slot_t  exe_s;
    slot_t  mem_s;
    state_t state_q;
    logic   raw_c;

    hazard_match u_hazard_match (
        .src1     (src1),
        .src2     (src2),
        .use_src1 (use_src1),
        .two_src  (Two_src),
        .id_valid (id_valid),
        .exe_s    (exe_s),
        .mem_s    (mem_s),
        .raw_c    (raw_c)
    );

    // Zero-latency controls; a held branch flushes once memory frees up
    always_comb begin
        freeze = 1'b0;
        flush  = 1'b0;
        hazard = 1'b0;
        if (!rst) begin
            freeze = mem_busy;
            flush  = branch_taken & ~mem_busy;
            hazard = raw_c & ~branch_taken & ~mem_busy;
        end
    end

    // Shadow slots, observational state and saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            exe_s     <= '0;
            mem_s     <= '0;
            state_q   <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!freeze) begin
                mem_s <= exe_s;
                if (hazard || flush) begin
                    exe_s <= '0;
                end else begin
                    exe_s.valid    <= id_valid;
                    exe_s.wb_en    <= WB_EN_ID;
                    exe_s.mem_r_en <= MEM_R_EN_ID;
                    exe_s.dest     <= Dest_ID;
                end
            end

            if (mem_busy) begin
                state_q <= WAIT;
            end else if (branch_taken) begin
                state_q <= FLUSH;
            end else if (raw_c) begin
                state_q <= STALL;
            end else begin
                state_q <= RUN;
            end

            if (hazard) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (flush) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

    logic unused_state;
    assign unused_state = ^state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        Two_src;
    logic        use_src1;
    logic        id_valid;
    logic        WB_EN_ID;
    logic        MEM_R_EN_ID;
    logic [3:0]  Dest_ID;
    logic        branch_taken;
    logic        mem_busy;
    logic        hazard;
    logic        flush;
    logic        freeze;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .src1         (src1),
        .src2         (src2),
        .Two_src      (Two_src),
        .use_src1     (use_src1),
        .id_valid     (id_valid),
        .WB_EN_ID     (WB_EN_ID),
        .MEM_R_EN_ID  (MEM_R_EN_ID),
        .Dest_ID      (Dest_ID),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .hazard       (hazard),
        .flush        (flush),
        .freeze       (freeze),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    // Reference model: the instructions one and two stages ahead of ID
    typedef struct {
        logic       v;
        logic       wb;
        logic       ld;
        logic [3:0] dest;
    } ins_t;

    ins_t ahead[$];
    int   st_m;
    int   fl_m;
    logic exp_h, exp_f, exp_z;
    logic obs_h, obs_f, obs_z;

`ifdef FORWARDING_EN
    localparam int EXP_ALU_STALL  = 0;
    localparam int EXP_LOAD_STALL = 1;
`else
    localparam int EXP_ALU_STALL  = 2;
    localparam int EXP_LOAD_STALL = 2;
`endif

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic writes_to(input ins_t x, input logic [3:0] s);
        return x.v && x.wb && (x.dest == s) && (s != 4'hF);
    endfunction

    function automatic logic model_raw();
        logic r;
        r = 1'b0;
`ifdef FORWARDING_EN
        if (ahead[0].ld)
            r = (use_src1 && writes_to(ahead[0], src1)) || (Two_src && writes_to(ahead[0], src2));
`else
        foreach (ahead[i])
            r = r || (use_src1 && writes_to(ahead[i], src1)) || (Two_src && writes_to(ahead[i], src2));
`endif
        return id_valid && r;
    endfunction

    task automatic model_eval();
        if (rst) begin
            exp_h = 1'b0; exp_f = 1'b0; exp_z = 1'b0;
        end else begin
            exp_z = mem_busy;
            exp_f = branch_taken && !mem_busy;
            exp_h = model_raw() && !branch_taken && !mem_busy;
        end
    endtask

    task automatic model_commit();
        ins_t bub;
        ins_t cur;
        bub = '{v: 1'b0, wb: 1'b0, ld: 1'b0, dest: 4'h0};
        if (rst) begin
            ahead.delete();
            ahead.push_back(bub);
            ahead.push_back(bub);
            st_m = 0;
            fl_m = 0;
        end else begin
            if (!exp_z) begin
                cur = '{v: id_valid, wb: WB_EN_ID, ld: MEM_R_EN_ID, dest: Dest_ID};
                if (exp_h || exp_f) cur = bub;
                ahead.push_front(cur);
                void'(ahead.pop_back());
            end
            if (exp_h && st_m < 65535) st_m++;
            if (exp_f && fl_m < 65535) fl_m++;
        end
    endtask

    // One cycle: inputs are already driven after a falling edge
    task automatic tick(input string tag);
        #1;
        model_eval();
        obs_h = hazard;
        obs_f = flush;
        obs_z = freeze;
        chk({tag, ".hazard"},    16'(hazard),  16'(exp_h));
        chk({tag, ".flush"},     16'(flush),   16'(exp_f));
        chk({tag, ".freeze"},    16'(freeze),  16'(exp_z));
        chk({tag, ".stall_cnt"}, stall_cnt,    16'(st_m));
        chk({tag, ".flush_cnt"}, flush_cnt,    16'(fl_m));
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic wb, input logic ld, input logic [3:0] d,
                         input logic u1, input logic [3:0] s1, input logic two, input logic [3:0] s2,
                         input logic br, input logic mb);
        id_valid = v; WB_EN_ID = wb; MEM_R_EN_ID = ld; Dest_ID = d;
        use_src1 = u1; src1 = s1; Two_src = two; src2 = s2;
        branch_taken = br; mem_busy = mb;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop(); tick("drain");
        nop(); tick("drain");
    endtask

    initial begin
        int n;
        logic [15:0] base;
        logic r_v, r_wb, r_ld, r_u1, r_two;
        logic [3:0] r_d, r_s1, r_s2;
        logic hold;

        ahead.push_back('{v: 1'b0, wb: 1'b0, ld: 1'b0, dest: 4'h0});
        ahead.push_back('{v: 1'b0, wb: 1'b0, ld: 1'b0, dest: 4'h0});
        st_m = 0;
        fl_m = 0;

        // Reset with every control input active: outputs must stay low
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 4'h1, 1'b1, 1'b1);
        @(negedge clk);
        tick("rst0");
        tick("rst1");
        rst = 1'b0;
        nop(); tick("idle");

        // ADD R1,R4,R5 then SUB R2,R1,R3 held in ID while stalled
        base = stall_cnt;
        drive(1'b1, 1'b1, 1'b0, 4'h1, 1'b1, 4'h4, 1'b1, 4'h5, 1'b0, 1'b0); tick("add_r1");
        n = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 4'h2, 1'b1, 4'h1, 1'b1, 4'h3, 1'b0, 1'b0); tick("sub_r1");
            if (obs_h) n++; else break;
        end
        chk("alu_raw_cycles", 16'(n), 16'(EXP_ALU_STALL));
        chk("alu_raw_stall_cnt", stall_cnt - base, 16'(EXP_ALU_STALL));

        // LDR R1 then ADD R2,R1,R3
        drain();
        base = stall_cnt;
        drive(1'b1, 1'b1, 1'b1, 4'h1, 1'b1, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0); tick("ldr_r1");
        n = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 4'h2, 1'b1, 4'h1, 1'b1, 4'h3, 1'b0, 1'b0); tick("use_r1");
            if (obs_h) n++; else break;
        end
        chk("load_use_cycles", 16'(n), 16'(EXP_LOAD_STALL));
        chk("load_use_stall_cnt", stall_cnt - base, 16'(EXP_LOAD_STALL));

        // Taken branch in the same cycle as a RAW: flush wins, EXE gets a bubble
        drain();
        base = flush_cnt;
        drive(1'b1, 1'b1, 1'b1, 4'h1, 1'b1, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0); tick("br_writer");
        drive(1'b1, 1'b1, 1'b1, 4'h6, 1'b1, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0); tick("br_raw");
        chk("br_flush", 16'(obs_f), 16'd1);
        chk("br_hazard", 16'(obs_h), 16'd0);
        chk("br_flush_cnt", flush_cnt - base, 16'd1);
        drive(1'b1, 1'b1, 1'b0, 4'h7, 1'b1, 4'h6, 1'b0, 4'h0, 1'b0, 1'b0); tick("br_bubble");
        chk("br_bubble_no_raw", 16'(obs_h), 16'd0);

        // Memory busy for 3 cycles over a pending RAW
        drain();
        drive(1'b1, 1'b1, 1'b1, 4'h1, 1'b1, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0); tick("mb_ldr");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 4'h2, 1'b1, 4'h1, 1'b1, 4'h3, 1'b0, 1'b1); tick("mb_busy");
            chk("mb_freeze", 16'(obs_z), 16'd1);
            chk("mb_hazard", 16'(obs_h), 16'd0);
        end
        drive(1'b1, 1'b1, 1'b0, 4'h2, 1'b1, 4'h1, 1'b1, 4'h3, 1'b0, 1'b0); tick("mb_resume");
        chk("mb_resume_hazard", 16'(obs_h), 16'd1);
        chk("mb_resume_freeze", 16'(obs_z), 16'd0);

        // PC index never creates a dependence
        drain();
        drive(1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0); tick("pc_writer");
        drive(1'b1, 1'b1, 1'b0, 4'h2, 1'b1, 4'hF, 1'b1, 4'hF, 1'b0, 1'b0); tick("pc_reader");
        chk("pc_no_hazard", 16'(obs_h), 16'd0);

        // Reset asserted in the middle of a stall
        drain();
        drive(1'b1, 1'b1, 1'b1, 4'h1, 1'b1, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0); tick("rs_ldr");
        drive(1'b1, 1'b1, 1'b0, 4'h2, 1'b1, 4'h1, 1'b1, 4'h3, 1'b0, 1'b0); tick("rs_stall");
        chk("rs_stall_hazard", 16'(obs_h), 16'd1);
        rst = 1'b1; tick("rs_in_reset");
        chk("rs_reset_hazard", 16'(obs_h), 16'd0);
        rst = 1'b0; tick("rs_after");
        chk("rs_after_hazard", 16'(obs_h), 16'd0);
        chk("rs_after_stall_cnt", stall_cnt, 16'd0);
        chk("rs_after_flush_cnt", flush_cnt, 16'd0);

        // Randomized traffic; the ID instruction holds while stalled or frozen
        hold = 1'b0;
        r_v = 1'b0; r_wb = 1'b0; r_ld = 1'b0; r_u1 = 1'b0; r_two = 1'b0;
        r_d = 4'h0; r_s1 = 4'h0; r_s2 = 4'h0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                r_v   = ($urandom_range(9) != 0);
                r_wb  = ($urandom_range(3) != 0);
                r_ld  = ($urandom_range(2) == 0);
                r_u1  = ($urandom_range(4) != 0);
                r_two = ($urandom_range(1) == 0);
                r_d   = ($urandom_range(7) == 0) ? 4'hF : 4'($urandom_range(3));
                r_s1  = ($urandom_range(7) == 0) ? 4'hF : 4'($urandom_range(3));
                r_s2  = 4'($urandom_range(3));
            end
            drive(r_v, r_wb, r_ld, r_d, r_u1, r_s1, r_two, r_s2,
                  ($urandom_range(7) == 0), ($urandom_range(7) == 0));
            rst = ($urandom_range(63) == 0);
            tick("rand");
            hold = !rst && (exp_h || exp_z);
        end
        rst = 1'b0;

        // Saturation: preload the stall counter, then three load-use stalls
        drain();
        nop();
        force dut.stall_cnt = 16'hFFFE;
        #1;
        release dut.stall_cnt;
        st_m = 65534;
        tick("sat_preload");
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b1, 4'h1, 1'b1, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0); tick("sat_ldr");
            drive(1'b1, 1'b1, 1'b0, 4'h2, 1'b1, 4'h1, 1'b1, 4'h3, 1'b0, 1'b0); tick("sat_use");
            chk("sat_use_hazard", 16'(obs_h), 16'd1);
            nop(); tick("sat_gap");
            nop(); tick("sat_gap");
        end
        chk("stall_cnt_saturated", stall_cnt, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
